// File: rtl/fft_pkg.sv
// Shared types, twiddle generation and saturation helpers for the radix-2 butterfly pipeline.
package fft_pkg;

    localparam int  CPLX_DW = 8;
    localparam real PI      = 3.14159265358979323846;

    function automatic int cplx_w(input int dw);
        return 2 * dw;
    endfunction

    typedef struct packed {
        logic signed [CPLX_DW-1:0] re;
        logic signed [CPLX_DW-1:0] im;
    } cplx_t;

    // Scale by 2^(w-1), round half away from zero, clamp magnitude to 2^(w-1)-1.
    function automatic int tw_round(input real v, input int w);
        int lim;
        int r;
        lim = (1 << (w - 1)) - 1;
        if (v >= 0.0) begin
            r = $rtoi(v + 0.5);
        end else begin
            r = -$rtoi(-v + 0.5);
        end
        if (r > lim) begin
            return lim;
        end else if (r < -lim) begin
            return -lim;
        end else begin
            return r;
        end
    endfunction

    function automatic int tw_re(input int k, input int n, input int w);
        return tw_round($cos(2.0 * PI * real'(k) / real'(n)) * real'(1 << (w - 1)), w);
    endfunction

    function automatic int tw_im(input int k, input int n, input int w);
        return tw_round(-$sin(2.0 * PI * real'(k) / real'(n)) * real'(1 << (w - 1)), w);
    endfunction

    localparam logic signed [7:0] TW8_RE [8] = '{8'sd127, 8'sd91, 8'sd0, -8'sd91,
                                                  -8'sd127, -8'sd91, 8'sd0, 8'sd91};
    localparam logic signed [7:0] TW8_IM [8] = '{8'sd0, -8'sd91, -8'sd127, -8'sd91,
                                                  8'sd0, 8'sd91, 8'sd127, 8'sd91};

    function automatic logic signed [31:0] sat_dw(input logic signed [31:0] x, input int dw,
                                                  input logic sat_en);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (!sat_en) begin
            return x;
        end else if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

    function automatic logic out_of_range(input logic signed [31:0] x, input int dw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        return (x > hi) || (x < lo);
    endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Registered twiddle lookup k -> W_N^k, conjugated when inv is set.
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int N    = 8,
    parameter int TW_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic [$clog2(N)-1:0]    k,
    input  logic                    inv,
    output logic signed [TW_W-1:0]  tr,
    output logic signed [TW_W-1:0]  ti
);

    logic signed [TW_W-1:0] tab_re_s [N];
    logic signed [TW_W-1:0] tab_im_s [N];

    for (genvar g = 0; g < N; g++) begin : g_tab
        if (N == 8 && TW_W == 8) begin : g_fixed
            assign tab_re_s[g] = TW8_RE[g];
            assign tab_im_s[g] = TW8_IM[g];
        end else begin : g_calc
            assign tab_re_s[g] = TW_W'(tw_re(g, N, TW_W));
            assign tab_im_s[g] = TW_W'(tw_im(g, N, TW_W));
        end
    end

    // Table read advances with the pipeline; clamped magnitudes make the negation safe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tr <= '0;
            ti <= '0;
        end else if (en) begin
            tr <= tab_re_s[k];
            ti <= inv ? -tab_im_s[k] : tab_im_s[k];
        end
    end

endmodule

// File: rtl/fft_bfly_pipe.sv
// Three-stage streaming radix-2 DIT butterfly: y = a + b*W, z = a - b*W with global-enable stall.
module fft_bfly_pipe
    import fft_pkg::*;
#(
    parameter int DW     = 8,
    parameter int TW_W   = 8,
    parameter int N      = 8,
    parameter bit SAT_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_ar,
    input  logic [DW-1:0]         in_ai,
    input  logic [DW-1:0]         in_br,
    input  logic [DW-1:0]         in_bi,
    input  logic [$clog2(N)-1:0]  in_k,
    input  logic                  in_inv,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_yr,
    output logic [DW-1:0]         out_yi,
    output logic [DW-1:0]         out_zr,
    output logic [DW-1:0]         out_zi,
    output logic                  out_ovf
);

    localparam int PW = DW + TW_W + 1;
    localparam int SW = DW + 2;
    localparam logic signed [PW-1:0] RND = PW'(64'sd1 <<< (TW_W - 2));

    logic                   en_s;
    logic                   v1_r;
    logic                   v2_r;
    logic signed [DW-1:0]   ar1_r, ai1_r, br1_r, bi1_r;
    logic signed [DW-1:0]   ar2_r, ai2_r;
    logic signed [TW_W-1:0] tr_s, ti_s;
    logic signed [PW-1:0]   pr_s, pi_s;
    logic signed [PW-1:0]   pr2_r, pi2_r;
    logic signed [SW-1:0]   mr_s, mi_s;
    logic signed [SW-1:0]   res_s [4];
    logic signed [DW-1:0]   q_s [4];
    logic                   ovf_s;

    assign en_s     = !out_valid || out_ready;
    assign in_ready = en_s;

    fft_twiddle_rom #(.N(N), .TW_W(TW_W)) u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en_s),
        .k       (in_k),
        .inv     (in_inv),
        .tr      (tr_s),
        .ti      (ti_s)
    );

    // Stage 1: capture operands alongside the registered twiddle lookup.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_r  <= 1'b0;
            ar1_r <= '0;
            ai1_r <= '0;
            br1_r <= '0;
            bi1_r <= '0;
        end else if (en_s) begin
            v1_r  <= in_valid;
            ar1_r <= signed'(in_ar);
            ai1_r <= signed'(in_ai);
            br1_r <= signed'(in_br);
            bi1_r <= signed'(in_bi);
        end
    end

    // Full-precision complex product b*W; operands widened first so nothing is lost.
    always_comb begin
        pr_s = PW'(br1_r) * PW'(tr_s) - PW'(bi1_r) * PW'(ti_s);
        pi_s = PW'(br1_r) * PW'(ti_s) + PW'(bi1_r) * PW'(tr_s);
    end

    // Stage 2: product registers, a forwarded unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2_r  <= 1'b0;
            ar2_r <= '0;
            ai2_r <= '0;
            pr2_r <= '0;
            pi2_r <= '0;
        end else if (en_s) begin
            v2_r  <= v1_r;
            ar2_r <= ar1_r;
            ai2_r <= ai1_r;
            pr2_r <= pr_s;
            pi2_r <= pi_s;
        end
    end

    // Round back to data scale, form y/z with two guard bits, then saturate or wrap.
    always_comb begin
        mr_s = SW'((pr2_r + RND) >>> (TW_W - 1));
        mi_s = SW'((pi2_r + RND) >>> (TW_W - 1));
        res_s[0] = SW'(ar2_r) + mr_s;
        res_s[1] = SW'(ai2_r) + mi_s;
        res_s[2] = SW'(ar2_r) - mr_s;
        res_s[3] = SW'(ai2_r) - mi_s;
        ovf_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q_s[i] = DW'(sat_dw(32'(res_s[i]), DW, SAT_EN));
            ovf_s  = ovf_s | out_of_range(32'(res_s[i]), DW);
        end
    end

    // Stage 3: output registers, held while downstream stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_yr    <= '0;
            out_yi    <= '0;
            out_zr    <= '0;
            out_zi    <= '0;
            out_ovf   <= 1'b0;
        end else if (en_s) begin
            out_valid <= v2_r;
            out_yr    <= q_s[0];
            out_yi    <= q_s[1];
            out_zr    <= q_s[2];
            out_zi    <= q_s[3];
            out_ovf   <= ovf_s & v2_r;
        end
    end

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// Directed bench for fft_bfly_pipe: saturating and wrapping instances share stimulus.
module tb_fft_bfly_pipe;

    typedef struct {
        int s[4];
        int w[4];
        int ovf;
    } exp_t;

    localparam int TW_RE_TB [8] = '{127, 91, 0, -91, -127, -91, 0, 91};
    localparam int TW_IM_TB [8] = '{0, -91, -127, -91, 0, 91, 127, 91};

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic              w_in_ready;
    logic signed [7:0] in_ar, in_ai, in_br, in_bi;
    logic [2:0]        in_k;
    logic              in_inv;
    logic              out_valid, w_out_valid;
    logic              out_ready;
    logic signed [7:0] out_yr, out_yi, out_zr, out_zi;
    logic signed [7:0] w_yr, w_yi, w_zr, w_zi;
    logic              out_ovf, w_ovf;

    int   n_cmp;
    int   n_bad;
    exp_t q[$];

    fft_bfly_pipe #(.DW(8), .TW_W(8), .N(8), .SAT_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi), .in_k(in_k), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_yr(out_yr), .out_yi(out_yi),
        .out_zr(out_zr), .out_zi(out_zi), .out_ovf(out_ovf)
    );

    fft_bfly_pipe #(.DW(8), .TW_W(8), .N(8), .SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi), .in_k(in_k), .in_inv(in_inv),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_yr(w_yr), .out_yi(w_yi),
        .out_zr(w_zr), .out_zi(w_zi), .out_ovf(w_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input int ar, input int ai, input int br, input int bi,
                                   input int k, input int inv);
        exp_t e;
        int tr, ti, pr, pi, mr, mi;
        int y[4];
        tr = TW_RE_TB[k];
        ti = (inv != 0) ? -TW_IM_TB[k] : TW_IM_TB[k];
        pr = br * tr - bi * ti;
        pi = br * ti + bi * tr;
        mr = (pr + 64) >>> 7;
        mi = (pi + 64) >>> 7;
        y[0] = ar + mr; y[1] = ai + mi; y[2] = ar - mr; y[3] = ai - mi;
        e.ovf = 0;
        for (int i = 0; i < 4; i++) begin
            e.s[i] = (y[i] > 127) ? 127 : ((y[i] < -128) ? -128 : y[i]);
            e.w[i] = ((y[i] + 128) & 255) - 128;
            if (y[i] > 127 || y[i] < -128) e.ovf = 1;
        end
        return e;
    endfunction

    task automatic drive(input int ar, input int ai, input int br, input int bi,
                         input int k, input int inv);
        in_ar  = 8'(ar);
        in_ai  = 8'(ai);
        in_br  = 8'(br);
        in_bi  = 8'(bi);
        in_k   = 3'(k);
        in_inv = 1'(inv);
    endtask

    // Scoreboard: handshakes are sampled mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        exp_t e;
        int   obs_s[4];
        int   obs_w[4];
        if (!reset_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    obs_s = '{int'(out_yr), int'(out_yi), int'(out_zr), int'(out_zi)};
                    obs_w = '{int'(w_yr), int'(w_yi), int'(w_zr), int'(w_zi)};
                    for (int i = 0; i < 4; i++) begin
                        chk($sformatf("sb_sat%0d", i), obs_s[i], e.s[i]);
                        chk($sformatf("sb_wrap%0d", i), obs_w[i], e.w[i]);
                    end
                    chk("sb_ovf", int'(out_ovf), e.ovf);
                    chk("sb_wrap_ovf", int'(w_ovf), e.ovf);
                    chk("sb_wrap_valid", int'(w_out_valid), 1);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(int'(in_ar), int'(in_ai), int'(in_br), int'(in_bi),
                                  int'(in_k), int'(in_inv)));
            end
        end
    end

    task automatic send_one(input string tag, input int ar, input int ai, input int br,
                            input int bi, input int k, input int inv, input int eyr,
                            input int eyi, input int ezr, input int ezi, input int eovf);
        int lat;
        @(posedge clk); #1;
        drive(ar, ai, br, bi, k, inv);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_yr"}, int'(out_yr), eyr);
        chk({tag, "_yi"}, int'(out_yi), eyi);
        chk({tag, "_zr"}, int'(out_zr), ezr);
        chk({tag, "_zi"}, int'(out_zi), ezi);
        chk({tag, "_ovf"}, int'(out_ovf), eovf);
    endtask

    initial begin
        int acc_cnt, idx, cnt, first, last;
        logic acc;
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_yr", int'(out_yr), 0);
        chk("rst_zi", int'(out_zi), 0);
        chk("rst_ovf", int'(out_ovf), 0);
        reset_n = 1'b1;

        send_one("t1", 10, 0, 64, 0, 0, 0, 74, 0, -54, 0, 0);
        send_one("t2_fwd", 10, 0, 64, 0, 2, 0, 10, -63, 10, 63, 0);
        send_one("t2_inv", 10, 0, 64, 0, 2, 1, 10, 64, 10, -64, 0);
        send_one("t3_sat", 100, 0, 100, 0, 0, 0, 127, 0, 1, 0, 1);
        chk("t3_wrap_yr", int'(w_yr), -57);
        chk("t3_wrap_ovf", int'(w_ovf), 1);

        // Stall with a full pipe.
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        idx = 0;
        acc_cnt = 0;
        drive(0, 0, 30, 5, 0, 0);
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                acc_cnt++;
                idx++;
                drive(idx * 10, -idx, 30 + idx, 5, idx, idx % 2);
            end
        end
        chk("stall_accepted", acc_cnt, 3);
        chk("stall_in_ready", int'(in_ready), 0);
        chk("stall_hold_yr", int'(out_yr), q[0].s[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("stall_hold_yi", int'(out_yi), q[0].s[1]);
        chk("stall_hold_zr", int'(out_zr), q[0].s[2]);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) cnt++;
            @(posedge clk); #1;
        end
        chk("drain_count", cnt, 3);

        // Back-to-back stream over every twiddle index.
        repeat (2) @(posedge clk);
        #1;
        cnt = 0;
        first = -1;
        last = -1;
        for (int c = 0; c < 24; c++) begin
            if (c < 8) begin
                drive(5, -3, 40, 20, c, 0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (out_valid) begin
                if (first < 0) first = c;
                last = c;
                cnt++;
            end
        end
        chk("stream_count", cnt, 8);
        chk("stream_span", last - first + 1, 8);

        // Reset with two beats in flight.
        @(posedge clk); #1;
        drive(20, 20, 50, -50, 1, 0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(-20, 7, 11, 90, 3, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid || w_out_valid) cnt++;
        end
        chk("rst_flush_valid", cnt, 0);
        send_one("t6_after", 10, 0, 64, 0, 0, 0, 74, 0, -54, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
